// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types and helpers for the bit-serial (slice-at-a-time) ALU.
//   alu_op_e        : the 16 ALU_cont operation codes (0011/1111 reserved)
//   alu_seq_state_e : sequencer states IDLE / RUN / DONE
// The helper functions describe how each op drives the slice adder, so the
// slice datapath and the top-level sequencer agree on operand inversion and
// on the carry injected into slice 0.
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,  // A & B
    OP_OR    = 4'b0001,  // A | B
    OP_ADD   = 4'b0010,  // A + B + Cin
    OP_RSV3  = 4'b0011,  // reserved
    OP_ANDNB = 4'b0100,  // A & ~B
    OP_ORNB  = 4'b0101,  // A | ~B
    OP_SUB   = 4'b0110,  // A - B - Cin
    OP_SLT   = 4'b0111,  // signed A < B
    OP_NAANDB = 4'b1000, // ~A & B
    OP_NAORB = 4'b1001,  // ~A | B
    OP_RSUB  = 4'b1010,  // B - A - Cin
    OP_SGT   = 4'b1011,  // signed A > B
    OP_NOR   = 4'b1100,  // ~(A | B)
    OP_NAND  = 4'b1101,  // ~(A & B)
    OP_NADD  = 4'b1110,  // ~A + ~B + Cin
    OP_RSVF  = 4'b1111   // reserved
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } alu_seq_state_e;

  // Ops whose result comes from the slice adder (including the compares).
  function automatic logic isArith(alu_op_e op);
    return op inside {OP_ADD, OP_SUB, OP_SLT, OP_RSUB, OP_SGT, OP_NADD};
  endfunction

  // Ops that report signed overflow.
  function automatic logic isOvfOp(alu_op_e op);
    return op inside {OP_ADD, OP_SUB, OP_RSUB, OP_NADD};
  endfunction

  // Subtraction is done as addition of the one's complement, so these tell
  // which adder operand is inverted.
  function automatic logic invertA(alu_op_e op);
    return op inside {OP_RSUB, OP_SGT, OP_NADD};
  endfunction

  function automatic logic invertB(alu_op_e op);
    return op inside {OP_SUB, OP_SLT, OP_NADD};
  endfunction

  // Carry into slice 0. Cin is a borrow on subtracts, so it enters inverted;
  // the compares always use a plain two's-complement subtract.
  function automatic logic initCarry(alu_op_e op, logic cin);
    case (op)
      OP_ADD, OP_NADD:  return cin;
      OP_SUB, OP_RSUB:  return ~cin;
      OP_SLT, OP_SGT:   return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_slice.sv
// ---------------------------------------------------------------------------
// alu_slice
// Combinational SLICE-bit ALU slice: bitwise logic ops or a ripple add with
// optional operand inversion, carry in and carry out.
// Ports:
//   i_op   : operation code (alu_op_e)
//   i_a    : SLICE-bit slice of operand A
//   i_b    : SLICE-bit slice of operand B
//   i_cin  : carry into this slice
//   o_x    : SLICE-bit slice result
//   o_cout : carry out of this slice (0 for non-arithmetic ops)
// ---------------------------------------------------------------------------
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  alu_op_e          i_op,
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_cin,
  output logic [SLICE-1:0] o_x,
  output logic             o_cout
);

  logic [SLICE-1:0] w_p;
  logic [SLICE-1:0] w_q;
  logic [SLICE:0]   w_sum;

  assign w_p   = invertA(i_op) ? ~i_a : i_a;
  assign w_q   = invertB(i_op) ? ~i_b : i_b;
  assign w_sum = {1'b0, w_p} + {1'b0, w_q} + (SLICE+1)'(i_cin);

  always_comb begin
    o_x    = '0;
    o_cout = 1'b0;
    case (i_op)
      OP_AND:    o_x = i_a & i_b;
      OP_OR:     o_x = i_a | i_b;
      OP_ANDNB:  o_x = i_a & ~i_b;
      OP_ORNB:   o_x = i_a | ~i_b;
      OP_NAANDB: o_x = ~i_a & i_b;
      OP_NAORB:  o_x = ~i_a | i_b;
      OP_NOR:    o_x = ~(i_a | i_b);
      OP_NAND:   o_x = ~(i_a & i_b);
      OP_ADD, OP_SUB, OP_SLT, OP_RSUB, OP_SGT, OP_NADD: begin
        o_x    = w_sum[SLICE-1:0];
        o_cout = w_sum[SLICE];
      end
      default: begin
        o_x    = '0;
        o_cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_slice_seq.sv
// ---------------------------------------------------------------------------
// alu_slice_seq
// Sequential ALU that processes a WIDTH-bit operation SLICE bits per cycle,
// LSB slice first, with the inter-slice carry held in a register. One op is
// accepted in IDLE, takes NSL = WIDTH/SLICE RUN cycles, and is held in DONE
// until the consumer takes it.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : request handshake (in_ready only in IDLE)
//   ALU_cont, A, B    : op code and operands, captured on acceptance
//   Cin               : carry-in (borrow-in on subtracts)
//   out_valid/out_ready : result handshake
//   X, Zero, Cout     : result, X==0 flag, final carry/borrow-out
//   Overflow          : signed overflow of add/sub ops (only when the macro
//                       ALU_SEQ_OVF_EN is defined)
// ---------------------------------------------------------------------------
module alu_slice_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_cont,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] X,
  output logic             Zero,
`ifdef ALU_SEQ_OVF_EN
  output logic             Overflow,
`endif
  output logic             Cout
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

  alu_seq_state_e   r_state;
  alu_op_e          r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_x;
  logic             r_zero;
  logic             r_cout;
  logic             r_outValid;
  logic             r_inReady;

  logic [SLICE-1:0] w_aSl;
  logic [SLICE-1:0] w_bSl;
  logic [SLICE-1:0] w_sliceX;
  logic             w_sliceCout;
  logic             w_last;
  logic             w_diffMsb;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_finalX;
  logic             w_finalCout;

  assign w_aSl     = r_a[int'(r_cnt)*SLICE +: SLICE];
  assign w_bSl     = r_b[int'(r_cnt)*SLICE +: SLICE];
  assign w_last    = (r_cnt == CW'(NSL-1));
  assign w_diffMsb = w_sliceX[SLICE-1];

  alu_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .i_op   (r_op),
    .i_a    (w_aSl),
    .i_b    (w_bSl),
    .i_cin  (r_carry),
    .o_x    (w_sliceX),
    .o_cout (w_sliceCout)
  );

  // Full result as it will look once the slice in flight is written: the
  // accumulator holds the lower slices, the live slice output fills the top.
  // Compares collapse to a single bit: when the sign bits differ the
  // subtraction can overflow, so the minuend's sign decides instead of the
  // difference MSB.
  always_comb begin
    w_sum                    = r_acc;
    w_sum[WIDTH-1 -: SLICE]  = w_sliceX;
    w_finalX                 = w_sum;
    w_finalCout              = 1'b0;
    case (r_op)
      OP_SLT: begin
        w_finalX    = '0;
        w_finalX[0] = (r_a[WIDTH-1] != r_b[WIDTH-1]) ? r_a[WIDTH-1] : w_diffMsb;
        w_finalCout = w_sliceCout;
      end
      OP_SGT: begin
        w_finalX    = '0;
        w_finalX[0] = (r_a[WIDTH-1] != r_b[WIDTH-1]) ? r_b[WIDTH-1] : w_diffMsb;
        w_finalCout = w_sliceCout;
      end
      OP_RSV3, OP_RSVF: begin
        w_finalX    = '0;
        w_finalCout = 1'b0;
      end
      default: begin
        w_finalX    = w_sum;
        w_finalCout = isArith(r_op) ? w_sliceCout : 1'b0;
      end
    endcase
  end

`ifdef ALU_SEQ_OVF_EN
  logic r_ovf;
  logic w_pSign;
  logic w_qSign;
  logic w_ovf;

  // Overflow of the adder as actually fed: both operands share a sign and
  // the sum's sign differs.
  assign w_pSign = invertA(r_op) ? ~r_a[WIDTH-1] : r_a[WIDTH-1];
  assign w_qSign = invertB(r_op) ? ~r_b[WIDTH-1] : r_b[WIDTH-1];
  assign w_ovf   = isOvfOp(r_op) && (w_pSign == w_qSign) && (w_diffMsb != w_pSign);
  assign Overflow = r_ovf;
`endif

  // Sequencer with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_op       <= OP_AND;
      r_a        <= '0;
      r_b        <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_x        <= '0;
      r_zero     <= 1'b0;
      r_cout     <= 1'b0;
      r_outValid <= 1'b0;
      r_inReady  <= 1'b1;
`ifdef ALU_SEQ_OVF_EN
      r_ovf      <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_op      <= alu_op_e'(ALU_cont);
            r_a       <= A;
            r_b       <= B;
            r_carry   <= initCarry(alu_op_e'(ALU_cont), Cin);
            r_cnt     <= '0;
            r_inReady <= 1'b0;
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_acc[int'(r_cnt)*SLICE +: SLICE] <= w_sliceX;
          r_carry <= w_sliceCout;
          if (w_last) begin
            r_x        <= w_finalX;
            r_zero     <= (w_finalX == '0);
            r_cout     <= w_finalCout;
            r_outValid <= 1'b1;
            r_cnt      <= '0;
            r_state    <= DONE;
`ifdef ALU_SEQ_OVF_EN
            r_ovf      <= w_ovf;
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_inReady  <= 1'b1;
          r_outValid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign X         = r_x;
  assign Zero      = r_zero;
  assign Cout      = r_cout;

endmodule

// File: tb/tb_alu_slice_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_slice_seq
// Directed bench for alu_slice_seq (WIDTH=32, SLICE=4). Expected results come
// from a whole-word reference model and are queued on acceptance, then popped
// and compared when out_valid rises. Overflow is checked only when
// ALU_SEQ_OVF_EN is defined.
// ---------------------------------------------------------------------------
module tb_alu_slice_seq;

  localparam int WIDTH = 32;
  localparam int SLICE = 4;
  localparam int NSL   = WIDTH / SLICE;
  localparam longint S32MAX = 64'sd2147483647;
  localparam longint S32MIN = -64'sd2147483648;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ALU_cont;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] X;
  logic             Zero;
  logic             Cout;
`ifdef ALU_SEQ_OVF_EN
  logic             Overflow;
`endif

  typedef struct {
    logic [31:0] x;
    logic        zero;
    logic        cout;
    logic        ovf;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle = 0;
  int   acceptCycle = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  alu_slice_seq #(
    .WIDTH (WIDTH),
    .SLICE (SLICE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALU_cont  (ALU_cont),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .X         (X),
    .Zero      (Zero),
`ifdef ALU_SEQ_OVF_EN
    .Overflow  (Overflow),
`endif
    .Cout      (Cout)
  );

  // Reference model working on whole words.
  function automatic exp_t model(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                 logic cin, string tag);
    exp_t        e;
    logic [32:0] s;
    longint      sa;
    longint      sbv;
    longint      lc;
    longint      r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    lc  = longint'({63'd0, cin});
    e.x = '0; e.cout = 1'b0; e.ovf = 1'b0; e.tag = tag;
    case (op)
      4'b0000: e.x = a & b;
      4'b0001: e.x = a | b;
      4'b0100: e.x = a & ~b;
      4'b0101: e.x = a | ~b;
      4'b1000: e.x = ~a & b;
      4'b1001: e.x = ~a | b;
      4'b1100: e.x = ~(a | b);
      4'b1101: e.x = ~(a & b);
      4'b0010: begin
        s = {1'b0, a} + {1'b0, b} + 33'(cin);
        e.x = s[31:0]; e.cout = s[32];
        r = sa + sbv + lc; e.ovf = (r > S32MAX) || (r < S32MIN);
      end
      4'b0110: begin
        e.x = a - b - 32'(cin);
        e.cout = (33'(a) >= 33'(b) + 33'(cin));
        r = sa - sbv - lc; e.ovf = (r > S32MAX) || (r < S32MIN);
      end
      4'b1010: begin
        e.x = b - a - 32'(cin);
        e.cout = (33'(b) >= 33'(a) + 33'(cin));
        r = sbv - sa - lc; e.ovf = (r > S32MAX) || (r < S32MIN);
      end
      4'b1110: begin
        s = {1'b0, ~a} + {1'b0, ~b} + 33'(cin);
        e.x = s[31:0]; e.cout = s[32];
        r = (-sa - 1) + (-sbv - 1) + lc; e.ovf = (r > S32MAX) || (r < S32MIN);
      end
      4'b0111: begin
        e.x = 32'($signed(a) < $signed(b));
        e.cout = (a >= b);
      end
      4'b1011: begin
        e.x = 32'($signed(a) > $signed(b));
        e.cout = (b >= a);
      end
      default: begin
        e.x = '0; e.cout = 1'b0;
      end
    endcase
    e.zero = (e.x == 32'd0);
    return e;
  endfunction

  task automatic checkEq(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents a request and returns at the negedge after
  // the acceptance edge, with the inputs scrambled so late changes are caught.
  task automatic applyStimulus(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                               logic cin, string tag);
    int waitCnt;
    in_valid = 1'b1; ALU_cont = op; A = a; B = b; Cin = cin;
    waitCnt = 0;
    while (in_ready !== 1'b1 && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    checkEq({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    if (in_ready !== 1'b1) begin
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(model(op, a, b, cin, tag));
    @(negedge clk);
    acceptCycle = cycle;
    in_valid = 1'b0;
    ALU_cont = 4'($urandom);
    A = $urandom;
    B = $urandom;
    Cin = 1'($urandom);
  endtask

  // Waits for the result, compares it against the scoreboard, optionally
  // holds off the consumer while offering a competing request, then
  // completes the handshake. Returns at a negedge.
  task automatic checkOutput(int hold, string tag);
    exp_t e;
    int   waitCnt;
    waitCnt = 0;
    while (out_valid !== 1'b1 && waitCnt < 40) begin
      @(negedge clk);
      waitCnt++;
    end
    checkEq({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    if (out_valid !== 1'b1 || sb.size() == 0) begin
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    checkEq({tag, " latency"}, 32'(cycle - acceptCycle), 32'(NSL));
    checkEq({tag, " X"}, X, e.x);
    checkEq({tag, " Zero"}, {31'd0, Zero}, {31'd0, e.zero});
    checkEq({tag, " Cout"}, {31'd0, Cout}, {31'd0, e.cout});
`ifdef ALU_SEQ_OVF_EN
    checkEq({tag, " Overflow"}, {31'd0, Overflow}, {31'd0, e.ovf});
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; ALU_cont = 4'b0001; A = 32'hDEAD0000; B = 32'h0000BEEF;
      @(negedge clk);
      checkEq({tag, " hold X"}, X, e.x);
      checkEq({tag, " hold out_valid"}, {31'd0, out_valid}, 32'd1);
      checkEq({tag, " hold in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkEq({tag, " post out_valid"}, {31'd0, out_valid}, 32'd0);
    checkEq({tag, " post in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  logic [3:0] opList [16];
  logic       sawValid;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ALU_cont = '0; A = '0; B = '0; Cin = 1'b0;
    repeat (2) @(negedge clk);
    checkEq("reset in_ready", {31'd0, in_ready}, 32'd1);
    checkEq("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkEq("reset X", X, 32'd0);
    checkEq("reset Zero", {31'd0, Zero}, 32'd0);
    checkEq("reset Cout", {31'd0, Cout}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(4'b0010, 32'hFFFFFFFF, 32'd1, 1'b0, "add_wrap");
    checkOutput(0, "add_wrap");
    applyStimulus(4'b0111, 32'h80000000, 32'd1, 1'b0, "slt");
    checkOutput(0, "slt");
    applyStimulus(4'b1011, 32'h80000000, 32'd1, 1'b0, "sgt");
    checkOutput(0, "sgt");
    applyStimulus(4'b0110, 32'd5, 32'd7, 1'b0, "sub_neg");
    checkOutput(0, "sub_neg");
    applyStimulus(4'b0110, 32'h80000000, 32'd1, 1'b0, "sub_ovf");
    checkOutput(0, "sub_ovf");
    applyStimulus(4'b0010, 32'h7FFFFFFF, 32'd0, 1'b1, "add_ovf");
    checkOutput(0, "add_ovf");

    for (int i = 0; i < 16; i++) opList[i] = 4'(i);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(opList[i], 32'hF0F01234, 32'h0FF0A5C3, 1'(i), $sformatf("op%b", opList[i]));
      checkOutput(0, $sformatf("op%b", opList[i]));
    end

    applyStimulus(4'b0010, 32'h12345678, 32'h11111111, 1'b1, "backpressure");
    checkOutput(5, "backpressure");

    applyStimulus(4'b0010, 32'h00000100, 32'h00000200, 1'b0, "killed");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    if (sb.size() > 0) void'(sb.pop_back());
    #1;
    checkEq("midrun reset out_valid", {31'd0, out_valid}, 32'd0);
    checkEq("midrun reset in_ready", {31'd0, in_ready}, 32'd1);
    checkEq("midrun reset X", X, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sawValid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid === 1'b1) sawValid = 1'b1;
    end
    checkEq("killed op no out_valid", {31'd0, sawValid}, 32'd0);
    applyStimulus(4'b1010, 32'd3, 32'd10, 1'b1, "after_reset");
    checkOutput(0, "after_reset");

    applyStimulus(4'b1111, 32'h1234, 32'h1234, 1'b1, "reserved");
    checkOutput(0, "reserved");

    checkEq("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_slice_seq.md
ALU_SLICE_SEQ -- requirements
Module: alu_slice_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values are multiples of SLICE, minimum 2*SLICE.
REQ-002 SHALL have parameter SLICE, default 4, bits processed per cycle; NSL = WIDTH/SLICE.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, block can accept a request.
REQ-007 SHALL have port ALU_cont, input, 4, operation code.
REQ-008 SHALL have ports A and B, input, WIDTH each, operands.
REQ-009 SHALL have port Cin, input, 1, carry-in; acts as borrow-in on subtract ops.
REQ-010 SHALL have port out_valid, output, 1, result present.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-012 SHALL have ports X (output, WIDTH, result), Zero (output, 1, X==0) and Cout (output, 1, final carry/borrow-out).

Function
REQ-013 SHALL use ALU_cont encoding: 0000 A&B, 0001 A|B, 0010 A+B+Cin, 0100 A&~B, 0101 A|~B, 0110 A-B-Cin, 0111 signed A<B, 1000 ~A&B, 1001 ~A|B, 1010 B-A-Cin, 1011 signed A>B, 1100 ~(A|B), 1101 ~(A&B), 1110 ~A+~B+Cin; 0011 and 1111 reserved.
REQ-014 SHALL use FSM states IDLE, RUN, DONE; IDLE->RUN on in_valid&&in_ready, RUN->DONE after slice NSL-1, DONE->IDLE on out_ready.
REQ-015 SHALL assert in_ready only in IDLE; on acceptance it registers ALU_cont, A, B and Cin, and later changes on those inputs are ignored.
REQ-016 SHALL process slice k (bits k*SLICE+SLICE-1 : k*SLICE) in RUN cycle k, k=0..NSL-1, with the carry registered between slices, LSB slice first.
REQ-017 SHALL assert out_valid exactly NSL cycles after the acceptance edge and hold X, Zero, Cout, out_valid stable until the out_ready handshake.
REQ-018 SHALL compute 0111 via A-B and 1011 via B-A with carry-in 1; result bit 0 = (sign bits differ) ? sign of minuend : MSB of difference; X upper bits 0; Cout = carry of that subtraction.
REQ-019 SHALL, for reserved ops, complete with normal latency and give X=0, Zero=1, Cout=0.
REQ-020 SHALL report Zero for the final X, including SLT/SGT results.
REQ-021 SHALL allow back-to-back traffic: the cycle after the DONE->IDLE transition has in_ready=1, giving a throughput of one op per NSL+2 cycles.
REQ-022 SHALL have no combinational path from inputs to in_ready or out_valid.

Reset
REQ-023 SHALL, on rst_n low at any time including mid-RUN, go to IDLE, abandon the current op and produce no out_valid for it.
REQ-024 SHALL reset outputs to in_ready=1 (while rst_n high), out_valid=0, X=0, Zero=0, Cout=0, and clear internal slice counter and carry to 0.

Configuration
REQ-025 SHALL, with macro ALU_SEQ_OVF_EN defined, add output Overflow (1 bit): signed overflow of ops 0010/0110/1010/1110, 0 otherwise, valid with out_valid and reset to 0.
REQ-026 SHALL, without ALU_SEQ_OVF_EN, omit the Overflow port and its logic entirely.

Structure
REQ-027 SHALL take an enum alu_op_e of the 16 codes and the state enum alu_seq_state_e from shared package alu_pkg.
REQ-028 SHALL instantiate one combinational sub-module alu_slice (SLICE-bit logic/add slice with carry in/out), used once per cycle.

Verification
REQ-029 SHALL cover, with WIDTH=32 and SLICE=4: 0010, A=32'hFFFFFFFF, B=1, Cin=0 -> X=0, Zero=1, Cout=1, out_valid 8 cycles after acceptance.
REQ-030 SHALL cover 0111, A=32'h80000000, B=1 -> X=1; and 1011 with the same operands -> X=0, Zero=1.
REQ-031 SHALL cover 0110, A=5, B=7, Cin=0 -> X=32'hFFFFFFFE, Cout=0; with ALU_SEQ_OVF_EN, A=32'h80000000, B=1 -> Overflow=1.
REQ-032 SHALL cover backpressure: out_ready held low 5 cycles -> X stable, in_ready=0 and a new in_valid ignored until the handshake.
REQ-033 SHALL cover rst_n pulsed low at RUN slice 3 -> out_valid never rises for that op, and the next request completes normally.
REQ-034 SHALL cover reserved op 1111, A=B=32'h1234 -> X=0, Zero=1, Cout=0, with normal latency.
